// File: rtl/roi_cfg_ctrl_pkg.sv
// Shared constants and state type for the ROI configuration controller.
// Coordinate words carry x in [26:16] and y in [9:0].
package roi_pkg;

    localparam int X_MSB = 26;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 9;
    localparam int Y_LSB = 0;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PEND  = 2'd2
    } state_t;

endpackage

// File: rtl/roi_cfg_ctrl_if.sv
// Request port of the ROI configuration controller (valid/ready plus payload).
interface roi_cfg_ctrl_if #(
    parameter int BIT_C = 32
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic             cfg_en_i;
    logic [BIT_C-1:0] cfg_xy0_i;
    logic [BIT_C-1:0] cfg_xy1_i;

    modport master (
        output cfg_valid_i, cfg_en_i, cfg_xy0_i, cfg_xy1_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_en_i, cfg_xy0_i, cfg_xy1_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/roi_cfg_ctrl_check.sv
// Combinational corner normalisation and range check for one ROI request.
// A disable request (i_en=0) always passes.
module roi_cfg_check
    import roi_pkg::*;
#(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int BIT_C  = 32
) (
    input  logic             i_en,
    input  logic [BIT_C-1:0] i_xy0,
    input  logic [BIT_C-1:0] i_xy1,
    output logic             o_ok,
    output logic [BIT_C-1:0] o_xy0,
    output logic [BIT_C-1:0] o_xy1,
    output logic [X_W-1:0]   o_w,
    output logic [Y_W-1:0]   o_h
);

    localparam logic [X_W:0] XLIM = (X_W+1)'(WIDTH);
    localparam logic [Y_W:0] YLIM = (Y_W+1)'(HEIGHT);

    logic [X_W-1:0] w_x_lo, w_x_hi;
    logic [Y_W-1:0] w_y_lo, w_y_hi;
    logic           w_unused_bits;

    assign w_unused_bits = ^{i_xy0[BIT_C-1:X_MSB+1], i_xy0[X_LSB-1:Y_MSB+1],
                             i_xy1[BIT_C-1:X_MSB+1], i_xy1[X_LSB-1:Y_MSB+1]};

    // Order each coordinate pair, then range-check the maxima and build outputs.
    always_comb begin
        if (i_xy0[X_MSB:X_LSB] > i_xy1[X_MSB:X_LSB]) begin
            w_x_lo = i_xy1[X_MSB:X_LSB];
            w_x_hi = i_xy0[X_MSB:X_LSB];
        end else begin
            w_x_lo = i_xy0[X_MSB:X_LSB];
            w_x_hi = i_xy1[X_MSB:X_LSB];
        end
        if (i_xy0[Y_MSB:Y_LSB] > i_xy1[Y_MSB:Y_LSB]) begin
            w_y_lo = i_xy1[Y_MSB:Y_LSB];
            w_y_hi = i_xy0[Y_MSB:Y_LSB];
        end else begin
            w_y_lo = i_xy0[Y_MSB:Y_LSB];
            w_y_hi = i_xy1[Y_MSB:Y_LSB];
        end
        o_ok = !i_en || (({1'b0, w_x_hi} < XLIM) && ({1'b0, w_y_hi} < YLIM));
        o_xy0 = {BIT_C{1'b0}};
        o_xy1 = {BIT_C{1'b0}};
        o_xy0[X_MSB:X_LSB] = w_x_lo;
        o_xy0[Y_MSB:Y_LSB] = w_y_lo;
        o_xy1[X_MSB:X_LSB] = w_x_hi;
        o_xy1[Y_MSB:Y_LSB] = w_y_hi;
        o_w = w_x_hi - w_x_lo + 11'd1;
        o_h = w_y_hi - w_y_lo + 10'd1;
    end

endmodule

// File: rtl/roi_cfg_ctrl.sv
// ROI configuration controller: validates crop requests and commits them to the
// crop datapath only at input-stream frame boundaries; counts enabled frames.
module roi_cfg_ctrl
    import roi_pkg::*;
#(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int BIT_C  = 32,
    parameter int FCNT_W = 16
) (
    input  logic              clk_i,
    input  logic              arst_i,
    roi_cfg_ctrl_if.slave     cfg,
    input  logic              tvalid_i,
    input  logic              tlast_i,
    output logic [BIT_C-1:0]  xy_0_o,
    output logic [BIT_C-1:0]  xy_1_o,
    output logic              roi_en_o,
    output logic [X_W-1:0]    roi_w_o,
    output logic [Y_W-1:0]    roi_h_o,
    output logic              commit_o,
    output logic              pend_o,
    output logic              err_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);

    state_t             r_state;
    logic               r_ready, r_commit, r_pend, r_err, r_in_frame;
    logic               r_req_en, r_sh_en, r_en;
    logic [BIT_C-1:0]   r_req_xy0, r_req_xy1, r_sh_xy0, r_sh_xy1, r_xy0, r_xy1;
    logic [X_W-1:0]     r_sh_w, r_w;
    logic [Y_W-1:0]     r_sh_h, r_h;
    logic [FCNT_W-1:0]  r_fcnt;

    logic               w_ok, w_last_beat, w_commit_pt;
    logic [BIT_C-1:0]   w_xy0, w_xy1;
    logic [X_W-1:0]     w_w;
    logic [Y_W-1:0]     w_h;

    roi_cfg_check #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_C(BIT_C)) u_check (
        .i_en  (r_req_en),
        .i_xy0 (r_req_xy0),
        .i_xy1 (r_req_xy1),
        .o_ok  (w_ok),
        .o_xy0 (w_xy0),
        .o_xy1 (w_xy1),
        .o_w   (w_w),
        .o_h   (w_h)
    );

    assign w_last_beat = tvalid_i && tlast_i;
    assign w_commit_pt = w_last_beat || (!r_in_frame && !tvalid_i);

    // Request FSM: capture, check, hold in shadow, commit at a frame boundary.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_commit  <= 1'b0;
            r_pend    <= 1'b0;
            r_err     <= 1'b0;
            r_req_en  <= 1'b0;
            r_req_xy0 <= {BIT_C{1'b0}};
            r_req_xy1 <= {BIT_C{1'b0}};
            r_sh_en   <= 1'b0;
            r_sh_xy0  <= {BIT_C{1'b0}};
            r_sh_xy1  <= {BIT_C{1'b0}};
            r_sh_w    <= {X_W{1'b0}};
            r_sh_h    <= {Y_W{1'b0}};
            r_en      <= 1'b0;
            r_xy0     <= {BIT_C{1'b0}};
            r_xy1     <= {BIT_C{1'b0}};
            r_w       <= {X_W{1'b0}};
            r_h       <= {Y_W{1'b0}};
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg.cfg_valid_i && r_ready) begin
                        r_req_en  <= cfg.cfg_en_i;
                        r_req_xy0 <= cfg.cfg_xy0_i;
                        r_req_xy1 <= cfg.cfg_xy1_i;
                        r_ready   <= 1'b0;
                        r_state   <= CHECK;
                    end else begin
                        r_ready   <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_ok) begin
                        r_err   <= 1'b0;
                        r_pend  <= 1'b1;
                        r_sh_en <= r_req_en;
                        // Disable keeps the last geometry so the outputs hold it.
                        if (r_req_en) begin
                            r_sh_xy0 <= w_xy0;
                            r_sh_xy1 <= w_xy1;
                            r_sh_w   <= w_w;
                            r_sh_h   <= w_h;
                        end else begin
                            r_sh_xy0 <= r_sh_xy0;
                        end
                        r_state <= PEND;
                    end else begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                PEND: begin
                    if (w_commit_pt) begin
                        r_en <= r_sh_en;
                        if (r_sh_en) begin
                            r_xy0 <= r_sh_xy0;
                            r_xy1 <= r_sh_xy1;
                            r_w   <= r_sh_w;
                            r_h   <= r_sh_h;
                        end else begin
                            r_xy0 <= r_xy0;
                        end
                        r_commit <= 1'b1;
                        r_pend   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_state <= PEND;
                    end
                end
                default: begin
                    r_pend  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Track whether the monitored stream is inside a frame.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_in_frame <= 1'b0;
        end else if (tvalid_i) begin
            r_in_frame <= !tlast_i;
        end else begin
            r_in_frame <= r_in_frame;
        end
    end

    // Count frames finished while cropping; uses the enable before any commit.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_fcnt <= {FCNT_W{1'b0}};
        end else if (w_last_beat && r_en) begin
            r_fcnt <= r_fcnt + FCNT_W'(1);
        end else begin
            r_fcnt <= r_fcnt;
        end
    end

    assign cfg.cfg_ready_o = r_ready;
    assign xy_0_o          = r_xy0;
    assign xy_1_o          = r_xy1;
    assign roi_en_o        = r_en;
    assign roi_w_o         = r_w;
    assign roi_h_o         = r_h;
    assign commit_o        = r_commit;
    assign pend_o          = r_pend;
    assign err_o           = r_err;
    assign frame_cnt_o     = r_fcnt;

endmodule
